// File: rtl/ifetch_queue.sv
// ifetch_queue
// Instruction fetch front end. Holds the fetch PC, presents its truncated byte
// address to a combinational instruction memory, captures the returned word
// into a small in-order queue and offers {pc, inst} pairs downstream through a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   imem_addr     byte address to instruction memory (fpc truncated)
//   imem_dout     instruction word returned in the same cycle
//   redirect      flush queue, restart fetch at redirect_pc
//   redirect_pc   new fetch byte address (low two bits ignored for fetch)
//   inst_valid    queue head holds a valid instruction
//   inst          instruction at queue head (0 while invalid)
//   inst_pc       byte PC of instruction at queue head (0 while invalid)
//   inst_ready    consumer accepts the head this cycle
//   misalign      one-cycle pulse after a redirect with redirect_pc[1:0] != 0
//   accept_count  handshakes completed since reset (wraps at 2^32)
module ifetch_queue #(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_dout,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       inst_ready,
    output logic                       misalign,
    output logic [31:0]                accept_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]      fpc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc   [QUEUE_DEPTH];
    logic [31:0]      q_inst [QUEUE_DEPTH];

    logic pop;
    logic push;

    assign imem_addr  = fpc[IMEM_ADDR_WIDTH-1:0];
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[head] : 32'h0;
    assign inst_pc    = inst_valid ? q_pc[head]   : 32'h0;

    assign pop = inst_valid & inst_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept
    // a new fetch while the head is being consumed.
    assign push = !redirect && ((count < CNT_W'(QUEUE_DEPTH)) || pop);

    // Control state: fetch PC, pointers, occupancy, status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc          <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            misalign     <= 1'b0;
            accept_count <= 32'h0;
        end else begin
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
            // A pop coincident with a redirect was still taken by the consumer.
            if (pop) begin
                accept_count <= accept_count + 32'd1;
            end
            if (redirect) begin
                fpc   <= {redirect_pc[31:2], 2'b00};
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                    fpc  <= fpc + 32'd4;
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Queue storage carries data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= fpc;
            q_inst[tail] <= imem_dout;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam int          AW    = 10;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_dout;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic          misalign;
    logic [31:0]   accept_count;

    logic [31:0] mem [256];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state
    logic [63:0] fq[$];
    logic [31:0] mfpc;
    logic        mmis;
    logic [31:0] macc;

    ifetch_queue #(
        .IMEM_ADDR_WIDTH(AW),
        .RESET_PC(RPC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_dout(imem_dout),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .misalign(misalign),
        .accept_count(accept_count)
    );

    always #5 clk = ~clk;

    assign imem_dout = mem[imem_addr[AW-1:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ev_inst;
        logic [31:0] ev_pc;
        ev_inst = 32'h0;
        ev_pc   = 32'h0;
        if (fq.size() != 0) begin
            ev_inst = fq[0][31:0];
            ev_pc   = fq[0][63:32];
        end
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, (fq.size() != 0)});
        chk("inst", inst, ev_inst);
        chk("inst_pc", inst_pc, ev_pc);
        chk("imem_addr", {22'h0, imem_addr}, {22'h0, mfpc[AW-1:0]});
        chk("misalign", {31'h0, misalign}, {31'h0, mmis});
        chk("accept_count", accept_count, macc);
    endtask

    // Drive one cycle: inputs applied while clk is low, outputs checked,
    // model advanced by the rules for this cycle, then wait out the edge.
    task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic m_pop;
        logic m_push;
        reset       = r;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        check_outputs();
        if (r) begin
            fq.delete();
            mfpc = RPC;
            mmis = 1'b0;
            macc = 32'h0;
        end else begin
            m_pop  = (fq.size() != 0) && rdy;
            m_push = !rd && ((fq.size() < DEPTH) || m_pop);
            if (m_pop) macc = macc + 32'd1;
            mmis = rd && (rpc[1:0] != 2'b00);
            if (rd) begin
                fq.delete();
                mfpc = {rpc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(fq.pop_front());
                if (m_push) begin
                    fq.push_back({mfpc, mem[mfpc[AW-1:2]]});
                    mfpc = mfpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rp;
        for (int i = 0; i < 256; i++) mem[i] = {i[7:0], 24'($urandom)};
        fq.delete();
        mfpc = 32'hx;
        mmis = 1'b0;
        macc = 32'h0;
        reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        // Reset; first cycle's outputs are unknown, so apply reset without checks.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fq.delete(); mfpc = RPC; mmis = 1'b0; macc = 32'h0;
        step(1, 0, 0, 0);

        // Streaming from reset with consumer always ready
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("acc_after_4", accept_count, 32'd4);

        // Backpressure, then release
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        #1 chk("stall_addr", {22'h0, imem_addr}, 32'(4 * DEPTH));
        chk("stall_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Redirect while full
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        #1 chk("redir_addr", {22'h0, imem_addr}, 32'h40);
        step(0, 1, 0, 0);
        #1 chk("redir_pc", inst_pc, 32'h40);
        chk("redir_inst", inst, mem[16]);
        step(0, 1, 0, 0);

        // Misaligned redirect
        step(0, 1, 1, 32'h43);
        #1 chk("mis_pulse", {31'h0, misalign}, 32'h1);
        step(0, 1, 0, 0);
        #1 chk("mis_clear", {31'h0, misalign}, 32'h0);
        chk("mis_pc", inst_pc, 32'h40);
        step(0, 1, 0, 0);

        // Redirect coincident with a pop
        step(0, 1, 1, 32'h0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h80);
        step(0, 1, 0, 0);
        #1 chk("redir_pop_pc", inst_pc, 32'h80);

        // Address wrap of the memory and of the full 32-bit PC
        step(0, 1, 1, 32'h3FC);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Mid-stream reset
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: rp = $urandom;
                1: rp = 32'h3F0 + 32'($urandom_range(0, 15));
                2: rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rp = 32'($urandom_range(0, 1023));
            endcase
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), rp);
        end
        #1 check_outputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch front end that acts as the reading initiator for the instruction memory. It holds the fetch PC, drives the memory's byte address each cycle, captures the combinational instruction word into a small in-order queue, and hands {pc, instruction} pairs downstream with a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at a new PC. It sits between the instruction memory and the decode stage.

## Interface
- IMEM_ADDR_WIDTH, 10, width of the instruction memory byte address (must match the memory instance).
- RESET_PC, 32'h0000_0000, fetch PC loaded during reset.
- QUEUE_DEPTH, 2, queue entries; legal values 2 or 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  IMEM_ADDR_WIDTH  byte address to the instruction memory; equals fpc[IMEM_ADDR_WIDTH-1:0].
- imem_dout  input  32  instruction word returned combinationally in the same cycle.
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch byte address.
- inst_valid  output  1  queue head holds a valid instruction.
- inst  output  32  instruction at the queue head.
- inst_pc  output  32  byte PC of the instruction at the queue head.
- inst_ready  input  1  consumer accepts the head this cycle.
- misalign  output  1  one-cycle pulse: the last redirect_pc had bits [1:0] != 0.
- accept_count  output  32  number of handshakes completed since reset.

## Operation
- State consists of fpc (32 bits), QUEUE_DEPTH entries of {pc, inst}, head/tail pointers, an occupancy count (0..QUEUE_DEPTH), misalign, and accept_count.
- pop = inst_valid & inst_ready. push = !redirect & (count < QUEUE_DEPTH | pop).
- On push: enqueue {fpc, imem_dout} at the tail, then fpc <= fpc + 4.
- When no push occurs and there is no redirect, fpc holds and imem_addr stays stable.
- Redirect has priority over everything except reset. It empties the queue (count <= 0, pointers reset) and sets fpc <= {redirect_pc[31:2], 2'b00}. No push occurs that cycle.
- misalign <= redirect & (redirect_pc[1:0] != 0). Otherwise misalign is 0 on the next cycle.
- A pop in the same cycle as a redirect still counts as accepted: the consumer has taken that instruction, and accept_count increments.
- Simultaneous push and pop at full occupancy is legal. Count stays at QUEUE_DEPTH and no entry is lost.
- Arithmetic wraps:
  - fpc 32'hFFFF_FFFC + 4 = 32'h0.
  - Pointers wrap modulo QUEUE_DEPTH.
  - accept_count wraps at 2^32.
  - imem_addr is plain truncation of fpc, so the memory address wraps every 2^IMEM_ADDR_WIDTH bytes.
- inst_valid = (count != 0). inst and inst_pc come from registers (the head entry), never directly from imem_dout.
- While inst_valid = 1 and inst_ready = 0, inst and inst_pc hold. A redirect may drop the head.

## Timing
- Reset (any cycle in which reset = 1):
  - fpc <= RESET_PC; count <= 0.
  - Next cycle: inst_valid = 0, misalign = 0, accept_count = 0.
  - inst and inst_pc are don't-care while inst_valid = 0; the RTL clears them to 0.
- Reset asserted mid-stream discards all queued entries and any pending redirect.
- Fetch-to-output latency is 1 cycle. An instruction fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- First cycle with reset = 0: imem_addr = RESET_PC truncated, and a push happens. The next cycle has inst_valid = 1 with inst_pc = RESET_PC.
- Redirect asserted in cycle N:
  - Cycle N+1: inst_valid = 0, and imem_addr shows the aligned redirect_pc.
  - Cycle N+2: inst_valid = 1 with the redirected instruction.
- Sustained throughput with inst_ready held at 1 is one instruction per cycle.
- With the queue full and inst_ready = 0, fpc stalls at the address of the next unfetched instruction.

## Test plan
- Reset release with RESET_PC = 0, memory words 0..3 = A, B, C, D, and inst_ready = 1 -> inst_pc sequence 0, 4, 8, 12 on consecutive cycles starting 1 cycle after reset drops; inst sequence A, B, C, D; accept_count = 4 after the 4th handshake.
- Backpressure: inst_ready = 0 for 5 cycles after the first valid -> inst_valid stays 1 and inst/inst_pc hold at A/0. Count reaches QUEUE_DEPTH; fpc stalls at 4*QUEUE_DEPTH. Releasing inst_ready yields 0, 4, 8, … with no gap and no duplicate.
- Redirect to 32'h40 while the queue is full -> next cycle inst_valid = 0 and imem_addr = 10'h040. The cycle after: inst_pc = 32'h40 and inst = word 16. misalign stays 0.
- Misaligned redirect to 32'h43 -> misalign pulses for exactly 1 cycle, and the fetch restarts at inst_pc = 32'h40.
- Redirect coincident with a pop of inst_pc = 8 -> accept_count increments by 1, no instruction from pc 12 or later is delivered, and the next delivered pc is redirect_pc.
- Wrap: redirect to 32'h3FC with IMEM_ADDR_WIDTH = 10 -> inst_pc 32'h3FC then 32'h400, with imem_addr 10'h3FC then 10'h000. Reset asserted for one cycle while valid -> inst_valid = 0 and accept_count = 0 next cycle, then restart at RESET_PC.
